// File: rtl/text_screen_sequencer.sv
// text_screen_sequencer
//
// Owns the single read/write port of the 80x25 text screen RAM (2048 x 16-bit
// words). Each RAM cycle ("slot") goes to one of two users. Single-word host
// accesses always win the slot. The bulk engine (fill all, fill row, scroll up,
// scroll down) takes every slot the host leaves free.
//
// Ports
//   clock, reset                  : rising-edge clock, async active-high reset
//   hostRequest/Write/Address/
//   hostDataIn                    : host access, held stable until hostReady
//   hostReady, hostDataOut        : one-cycle completion pulse and read data,
//                                   registered two edges after the sample edge
//   cmdValid, cmdReady, cmdOp,
//   cmdRow, cmdFill               : bulk command; accepted when valid && ready
//   busy, done                    : engine executing / one-cycle completion pulse
//   ramEnable, ramWriteEnable,
//   ramAddress, ramDataOut        : registered RAM port controls
//   ramDataIn                     : RAM read data, one cycle after the read edge
//
// Handshakes: the host request is sampled on an edge where the host side is idle
// and hostRequest=1. The access is issued on that same edge. The host side then
// ignores hostRequest for two edges, raising hostReady on the second. A command
// transfers on an edge where cmdValid && cmdReady. cmdReady is high only while
// the engine is in IDLE.
module text_screen_sequencer #(
    parameter int COLUMNS = 80,
    parameter int ROWS    = 25
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        hostRequest,
    input  logic        hostWrite,
    input  logic [10:0] hostAddress,
    input  logic [15:0] hostDataIn,
    output logic        hostReady,
    output logic [15:0] hostDataOut,
    input  logic        cmdValid,
    output logic        cmdReady,
    input  logic [1:0]  cmdOp,
    input  logic [4:0]  cmdRow,
    input  logic [15:0] cmdFill,
    output logic        busy,
    output logic        done,
    output logic        ramEnable,
    output logic        ramWriteEnable,
    output logic [10:0] ramAddress,
    output logic [15:0] ramDataOut,
    input  logic [15:0] ramDataIn
);

    localparam logic [10:0] COLS11        = 11'(COLUMNS);
    localparam logic [10:0] CELLS         = 11'(COLUMNS * ROWS);
    localparam logic [10:0] LAST_CELL     = CELLS - 11'd1;
    localparam logic [10:0] LAST_ROW_BASE = 11'((ROWS - 1) * COLUMNS);
    // Last destination of each copy pass. Scroll up ends just below the last
    // row. Scroll down ends at the first cell of row 1.
    localparam logic [10:0] UP_COPY_LAST  = LAST_ROW_BASE - 11'd1;
    localparam logic [10:0] DN_COPY_LAST  = COLS11;

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_WAIT, S_WRITE, S_FILL, S_DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_FILL_ALL, OP_FILL_ROW, OP_SCROLL_UP, OP_SCROLL_DOWN
    } op_t;

    state_t      state_q, state_d;
    op_t         op_q, op_d;
    logic [15:0] fill_q, fill_d;
    logic [10:0] addr_q, addr_d;      // current destination address
    logic [10:0] last_q, last_d;      // last address of the current fill run
    logic [15:0] data_q;              // word captured by a copy
    logic [1:0]  cap_q;               // read-issue pipeline: bit 1 => capture now
    logic        rd_issue;

    logic [1:0]  host_phase_q, host_phase_d;
    logic        host_wr_q, host_wr_d;
    logic        host_ready_q, host_ready_d;
    logic [15:0] host_dout_q, host_dout_d;
    logic        done_q, done_d;

    logic        ram_en_q, ram_en_d;
    logic        ram_we_q, ram_we_d;
    logic [10:0] ram_addr_q, ram_addr_d;
    logic [15:0] ram_data_q, ram_data_d;

    logic        host_go;
    logic        cap_now;
    logic        row_valid;
    logic [10:0] row_base;
    logic [10:0] src_addr;
    logic [15:0] copy_word;

    assign host_go   = (host_phase_q == 2'd0) && hostRequest;
    assign cap_now   = cap_q[1];
    assign row_valid = int'(cmdRow) < ROWS;
    assign row_base  = 11'(cmdRow) * COLS11;
    assign src_addr  = (op_q == OP_SCROLL_UP) ? addr_q + COLS11 : addr_q - COLS11;
    // The word arrives on the same edge as an uncontended WRITE. A WRITE
    // delayed by the host uses the copy captured on that edge.
    assign copy_word = cap_now ? ramDataIn : data_q;

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        fill_d       = fill_q;
        addr_d       = addr_q;
        last_d       = last_q;
        rd_issue     = 1'b0;
        done_d       = 1'b0;
        host_phase_d = host_phase_q;
        host_wr_d    = host_wr_q;
        host_ready_d = 1'b0;
        host_dout_d  = host_dout_q;
        ram_en_d     = 1'b0;
        ram_we_d     = 1'b0;
        ram_addr_d   = ram_addr_q;
        ram_data_d   = ram_data_q;

        // Host side: issue on the sample edge, complete two edges later.
        case (host_phase_q)
            2'd0: begin
                if (hostRequest) begin
                    host_phase_d = 2'd1;
                    host_wr_d    = hostWrite;
                    ram_en_d     = 1'b1;
                    ram_we_d     = hostWrite;
                    ram_addr_d   = hostAddress;
                    ram_data_d   = hostDataIn;
                end
            end
            2'd1: host_phase_d = 2'd2;
            default: begin
                host_phase_d = 2'd0;
                host_ready_d = 1'b1;
                if (!host_wr_q) begin
                    host_dout_d = ramDataIn;
                end
            end
        endcase

        // Engine: states that need a slot hold when the host has taken it.
        case (state_q)
            S_IDLE: begin
                if (cmdValid) begin
                    op_d   = op_t'(cmdOp);
                    fill_d = cmdFill;
                    case (op_t'(cmdOp))
                        OP_FILL_ALL: begin
                            addr_d  = 11'd0;
                            last_d  = LAST_CELL;
                            state_d = S_FILL;
                        end
                        OP_FILL_ROW: begin
                            if (row_valid) begin
                                addr_d  = row_base;
                                last_d  = row_base + COLS11 - 11'd1;
                                state_d = S_FILL;
                            end else begin
                                state_d = S_DONE;
                            end
                        end
                        OP_SCROLL_UP: begin
                            addr_d  = 11'd0;
                            state_d = S_READ;
                        end
                        default: begin
                            addr_d  = LAST_CELL;
                            state_d = S_READ;
                        end
                    endcase
                end
            end
            S_READ: begin
                if (!host_go) begin
                    ram_en_d   = 1'b1;
                    ram_we_d   = 1'b0;
                    ram_addr_d = src_addr;
                    rd_issue   = 1'b1;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: state_d = S_WRITE;
            S_WRITE: begin
                if (!host_go) begin
                    ram_en_d   = 1'b1;
                    ram_we_d   = 1'b1;
                    ram_addr_d = addr_q;
                    ram_data_d = copy_word;
                    if (op_q == OP_SCROLL_UP && addr_q == UP_COPY_LAST) begin
                        addr_d  = LAST_ROW_BASE;
                        last_d  = LAST_CELL;
                        state_d = S_FILL;
                    end else if (op_q != OP_SCROLL_UP && addr_q == DN_COPY_LAST) begin
                        addr_d  = 11'd0;
                        last_d  = COLS11 - 11'd1;
                        state_d = S_FILL;
                    end else begin
                        addr_d  = (op_q == OP_SCROLL_UP) ? addr_q + 11'd1 : addr_q - 11'd1;
                        state_d = S_READ;
                    end
                end
            end
            S_FILL: begin
                if (!host_go) begin
                    ram_en_d   = 1'b1;
                    ram_we_d   = 1'b1;
                    ram_addr_d = addr_q;
                    ram_data_d = fill_q;
                    if (addr_q == last_q) begin
                        state_d = S_DONE;
                    end else begin
                        addr_d = addr_q + 11'd1;
                    end
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            op_q         <= OP_FILL_ALL;
            fill_q       <= 16'd0;
            addr_q       <= 11'd0;
            last_q       <= 11'd0;
            data_q       <= 16'd0;
            cap_q        <= 2'b00;
            host_phase_q <= 2'd0;
            host_wr_q    <= 1'b0;
            host_ready_q <= 1'b0;
            host_dout_q  <= 16'd0;
            done_q       <= 1'b0;
            ram_en_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= 11'd0;
            ram_data_q   <= 16'd0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            fill_q       <= fill_d;
            addr_q       <= addr_d;
            last_q       <= last_d;
            cap_q        <= {cap_q[0], rd_issue};
            if (cap_now) begin
                data_q <= ramDataIn;
            end
            host_phase_q <= host_phase_d;
            host_wr_q    <= host_wr_d;
            host_ready_q <= host_ready_d;
            host_dout_q  <= host_dout_d;
            done_q       <= done_d;
            ram_en_q     <= ram_en_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_data_q   <= ram_data_d;
        end
    end

    assign hostReady      = host_ready_q;
    assign hostDataOut    = host_dout_q;
    assign cmdReady       = (state_q == S_IDLE);
    assign busy           = (state_q != S_IDLE);
    assign done           = done_q;
    assign ramEnable      = ram_en_q;
    assign ramWriteEnable = ram_we_q;
    assign ramAddress     = ram_addr_q;
    assign ramDataOut     = ram_data_q;

endmodule

// File: tb/tb_text_screen_sequencer.sv
// Bench for text_screen_sequencer. It contains a RAM model with 1-cycle read
// latency, a row-level reference model of the screen, and a host scoreboard
// whose monitor pops the expected queue whenever hostReady is seen.
module tb_text_screen_sequencer;

    localparam int COLS  = 80;
    localparam int ROWS  = 25;
    localparam int CELLS = COLS * ROWS;

    // clock / reset
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic        hostRequest, hostWrite, hostReady;
    logic [10:0] hostAddress;
    logic [15:0] hostDataIn, hostDataOut;
    logic        cmdValid, cmdReady, busy, done;
    logic [1:0]  cmdOp;
    logic [4:0]  cmdRow;
    logic [15:0] cmdFill;
    logic        ramEnable, ramWriteEnable;
    logic [10:0] ramAddress;
    logic [15:0] ramDataOut, ramDataIn;

    text_screen_sequencer #(.COLUMNS(COLS), .ROWS(ROWS)) dut (
        .clock(clock), .reset(reset),
        .hostRequest(hostRequest), .hostWrite(hostWrite), .hostAddress(hostAddress),
        .hostDataIn(hostDataIn), .hostReady(hostReady), .hostDataOut(hostDataOut),
        .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdOp(cmdOp), .cmdRow(cmdRow),
        .cmdFill(cmdFill), .busy(busy), .done(done),
        .ramEnable(ramEnable), .ramWriteEnable(ramWriteEnable), .ramAddress(ramAddress),
        .ramDataOut(ramDataOut), .ramDataIn(ramDataIn)
    );

    // RAM model
    logic [15:0] ram [0:2047];
    logic [15:0] ram_rd_q;
    logic        preload_go = 1'b0;
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    assign ramDataIn = ram_rd_q;

    always @(posedge clock) begin
        if (preload_go) begin
            for (int a = 0; a < 2048; a++) ram[a] <= 16'(a);
        end else if (ramEnable) begin
            if (ramWriteEnable) begin
                ram[ramAddress] <= ramDataOut;
                wr_cnt <= wr_cnt + 1;
            end else begin
                ram_rd_q <= ram[ramAddress];
                rd_cnt <= rd_cnt + 1;
            end
        end
    end

    // reference model and scoreboard state
    logic [15:0] ref_mem [0:2047];
    logic [15:0] exp_q[$];
    int          due_q[$];
    bit          chk_q[$];
    logic [10:0] adr_q[$];
    int          cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = -1;
    int          n_pass = 0;
    int          n_total = 0;
    bit          eng_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic int exp_cycles(input logic [1:0] op, input logic [4:0] row);
        if (op == 2'd0) return CELLS + 1;
        if (op == 2'd1) return (int'(row) < ROWS) ? COLS + 1 : 1;
        return (ROWS - 1) * COLS * 3 + COLS + 1;
    endfunction

    function automatic int exp_writes(input logic [1:0] op, input logic [4:0] row);
        if (op == 2'd1) return (int'(row) < ROWS) ? COLS : 0;
        return CELLS;
    endfunction

    // Screen-level effect of each command, row by row.
    task automatic ref_apply(input logic [1:0] op, input logic [4:0] row, input logic [15:0] f);
        case (op)
            2'd0: for (int a = 0; a < CELLS; a++) ref_mem[a] = f;
            2'd1: if (int'(row) < ROWS)
                      for (int c = 0; c < COLS; c++) ref_mem[int'(row) * COLS + c] = f;
            2'd2: begin
                for (int r = 0; r < ROWS - 1; r++)
                    for (int c = 0; c < COLS; c++) ref_mem[r * COLS + c] = ref_mem[(r + 1) * COLS + c];
                for (int c = 0; c < COLS; c++) ref_mem[(ROWS - 1) * COLS + c] = f;
            end
            default: begin
                for (int r = ROWS - 1; r > 0; r--)
                    for (int c = 0; c < COLS; c++) ref_mem[r * COLS + c] = ref_mem[(r - 1) * COLS + c];
                for (int c = 0; c < COLS; c++) ref_mem[c] = f;
            end
        endcase
    endtask

    task automatic preload();
        preload_go = 1'b1;
        @(negedge clock);
        preload_go = 1'b0;
        for (int a = 0; a < 2048; a++) ref_mem[a] = 16'(a);
    endtask

    task automatic compare_mem(input string nm);
        int nbad;
        int first;
        nbad = 0;
        first = -1;
        for (int a = 0; a < 2048; a++) begin
            if (ram[a] !== ref_mem[a]) begin
                nbad++;
                if (first < 0) first = a;
            end
        end
        n_total++;
        if (nbad == 0) n_pass++;
        else $display("FAIL %s contents: %0d cells differ, mem[%0d]=%h expected %h",
                      nm, nbad, first, ram[first], ref_mem[first]);
    endtask

    // host driver: called at a negedge; returns at the negedge showing hostReady
    task automatic host_access(input bit wr, input logic [10:0] addr, input logic [15:0] data,
                               input bit chk, output int sample);
        bit got;
        hostRequest = 1'b1;
        hostWrite   = wr;
        hostAddress = addr;
        hostDataIn  = data;
        sample      = cyc + 1;
        if (wr) ref_mem[addr] = data;
        exp_q.push_back(wr ? 16'h0000 : ref_mem[addr]);
        due_q.push_back(sample + 2);
        chk_q.push_back(chk && !wr);
        adr_q.push_back(addr);
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clock);
            if (hostReady) got = 1'b1;
        end
        if (!got) check("host_ready_timeout", 32'd0, 32'd1);
        hostRequest = 1'b0;
    endtask

    // command driver: called at a negedge; returns acceptance and done edges
    task automatic run_cmd(input logic [1:0] op, input logic [4:0] row, input logic [15:0] f,
                           output int acc, output int dc);
        int d0;
        cmdValid = 1'b1;
        cmdOp    = op;
        cmdRow   = row;
        cmdFill  = f;
        acc      = -1;
        dc       = -1;
        for (int i = 0; i < 20 && acc < 0; i++) begin
            if (cmdReady) acc = cyc + 1;
            @(negedge clock);
        end
        cmdValid = 1'b0;
        if (acc < 0) begin
            check("cmd_accept_timeout", 32'd0, 32'd1);
            return;
        end
        check("busy_ready_after_accept", 32'({busy, cmdReady}), 32'b10);
        d0 = done_cnt;
        for (int i = 0; i < 20000 && done_cnt == d0; i++) @(negedge clock);
        if (done_cnt == d0) check("done_timeout", 32'd0, 32'd1);
        else dc = done_cyc;
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [4:0] row, input logic [15:0] f);
        int acc, dc, w0, r0;
        string nm;
        nm = $sformatf("op%0d_row%0d", op, row);
        w0 = wr_cnt;
        r0 = rd_cnt;
        run_cmd(op, row, f, acc, dc);
        ref_apply(op, row, f);
        check({nm, "_cycles"}, 32'(dc - acc), 32'(exp_cycles(op, row)));
        check({nm, "_writes"}, 32'(wr_cnt - w0), 32'(exp_writes(op, row)));
        check({nm, "_reads"}, 32'(rd_cnt - r0), (op[1] ? 32'((ROWS - 1) * COLS) : 32'd0));
        compare_mem(nm);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    initial begin
        int s, acc, dc, nh;
        int samples[$];
        logic [1:0] op;
        logic [4:0] row;
        reset = 1'b1;
        hostRequest = 1'b0; hostWrite = 1'b0; hostAddress = '0; hostDataIn = '0;
        cmdValid = 1'b0; cmdOp = '0; cmdRow = '0; cmdFill = '0;

        fork
            forever @(posedge clock) cyc++;
            forever begin
                @(negedge clock);
                if (hostReady) begin
                    if (exp_q.size() == 0) begin
                        check("host_unexpected_ready", 32'd1, 32'd0);
                    end else begin
                        logic [15:0] e;
                        int d;
                        bit c;
                        logic [10:0] a;
                        e = exp_q.pop_front();
                        d = due_q.pop_front();
                        c = chk_q.pop_front();
                        a = adr_q.pop_front();
                        check($sformatf("host_latency[%0d]", a), 32'(cyc), 32'(d));
                        if (c) check($sformatf("host_read[%0d]", a), 32'(hostDataOut), 32'(e));
                    end
                end
                if (done) begin
                    done_cyc = cyc;
                    done_cnt++;
                    check("busy_low_with_done", 32'(busy), 32'd0);
                end
            end
        join_none

        // reset state
        @(negedge clock);
        check("rst_ramEnable", 32'(ramEnable), 32'd0);
        check("rst_ramWriteEnable", 32'(ramWriteEnable), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cmdReady", 32'(cmdReady), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_host", 32'({hostReady, hostDataOut}), 32'd0);
        preload();
        reset = 1'b0;
        @(negedge clock);

        // directed host write then read
        host_access(1'b1, 11'd5, 16'h1F41, 1'b1, s);
        host_access(1'b0, 11'd5, 16'h0000, 1'b1, s);

        // random host traffic on an idle engine
        for (int i = 0; i < 16; i++)
            host_access(1'($urandom_range(0, 1)), 11'($urandom_range(0, 2047)), 16'($urandom), 1'b1, s);

        // bulk commands against a known preload
        do_cmd(2'd0, 5'd0, 16'h0720);
        host_access(1'b0, 11'd1999, 16'h0, 1'b1, s);
        host_access(1'b0, 11'd2000, 16'h0, 1'b1, s);
        do_cmd(2'd1, 5'd24, 16'h4E2A);
        do_cmd(2'd1, 5'd25, 16'h1234);
        preload();
        do_cmd(2'd2, 5'd0, 16'h0000);
        preload();
        do_cmd(2'd3, 5'd0, 16'hABCD);

        // reset in the middle of a scroll up
        cmdValid = 1'b1; cmdOp = 2'd2; cmdRow = 5'd0; cmdFill = 16'h5555;
        @(negedge clock);
        cmdValid = 1'b0;
        repeat (100) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("midrst_ramEnable", 32'(ramEnable), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_cmdReady", 32'(cmdReady), 32'd1);
        check("midrst_done", 32'(done), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("postrst_idle", 32'({ramEnable, busy, cmdReady}), 32'b001);
        for (int a = 0; a < 2048; a++) ref_mem[a] = ram[a];
        do_cmd(2'd0, 5'd0, 16'h1111);

        // FILL_ALL with a host read issued every 3 cycles
        eng_done = 1'b0;
        samples.delete();
        fork
            begin
                run_cmd(2'd0, 5'd0, 16'h2222, acc, dc);
                eng_done = 1'b1;
            end
            begin
                while (!eng_done) begin
                    host_access(1'b0, 11'($urandom_range(0, 2047)), 16'h0, 1'b0, s);
                    samples.push_back(s);
                end
            end
        join
        nh = 0;
        foreach (samples[i]) if (samples[i] > acc && samples[i] < dc) nh++;
        check("contended_host_count_nonzero", 32'(nh > 100), 32'd1);
        check("contended_fill_cycles", 32'(dc - acc), 32'(CELLS + 1 + nh));
        ref_apply(2'd0, 5'd0, 16'h2222);
        compare_mem("contended_fill");

        // random commands, each followed by a few checked host reads
        for (int i = 0; i < 4; i++) begin
            op  = 2'($urandom_range(0, 3));
            row = 5'($urandom_range(0, 31));
            do_cmd(op, row, 16'($urandom));
            for (int j = 0; j < 4; j++)
                host_access(1'b0, 11'($urandom_range(0, 2047)), 16'h0, 1'b1, s);
        end

        repeat (4) @(negedge clock);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/text_screen_sequencer.md
# text_screen_sequencer

Controller that owns the read/write port of the 80x25 text screen RAM: 2048 x 16-bit words, one word per cell (code point plus attribute). It time-shares that port between single-word host (CPU bus) accesses and a bulk-operation engine. The engine performs screen fill, row fill, scroll up and scroll down. It sits between the system bus bridge and the screen RAM; the renderer's read-only port is untouched.

## Interface
- COLUMNS, 80, cells per row
- ROWS, 25, rows per screen; COLUMNS*ROWS must be ≤ 2048
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- hostRequest  in  1  host access request; held with fields stable until hostReady
- hostWrite  in  1  1 = write, 0 = read
- hostAddress  in  11  word address
- hostDataIn  in  16  write data
- hostReady  out  1  one-cycle completion pulse
- hostDataOut  out  16  read data, valid while hostReady
- cmdValid  in  1  bulk command offered
- cmdReady  out  1  high when the engine is idle
- cmdOp  in  2  0 FILL_ALL, 1 FILL_ROW, 2 SCROLL_UP, 3 SCROLL_DOWN
- cmdRow  in  5  row for FILL_ROW
- cmdFill  in  16  fill word (code point and attribute)
- busy  out  1  engine executing
- done  out  1  one-cycle pulse at engine completion
- ramEnable, ramWriteEnable  out  1 each  to RAM port enable / write enable
- ramAddress  out  11  to RAM port address
- ramDataOut  out  16  to RAM port write data
- ramDataIn  in  16  from RAM port read data (1-cycle read latency)

## Operation
- All ram* outputs are registered. There is at most one RAM access per cycle, called a "slot".
- Arbitration uses fixed priority: host first. If the host wants a slot in the same cycle as the engine, the host wins and the engine holds its state and counters.
- Host port: at most one access is outstanding.
  - The request is sampled at edge k, and the RAM access is issued on edge k.
  - hostReady and hostDataOut are registered at edge k+2.
  - hostRequest is ignored on edge k+1 and edge k+2, and is sampled again from edge k+3.
- Command acceptance: a command is accepted on an edge where cmdValid && cmdReady. cmdOp, cmdRow and cmdFill are latched at acceptance. From the next cycle, busy=1 and cmdReady=0.
- Engine states: IDLE, READ, WAIT, WRITE, FILL, DONE.
  - FILL_ALL: FILL state writes cmdFill to addresses 0..COLUMNS*ROWS-1, ascending. Addresses COLUMNS*ROWS..2047 are never touched.
  - FILL_ROW: FILL state writes cmdRow*COLUMNS .. cmdRow*COLUMNS+COLUMNS-1. If cmdRow ≥ ROWS, there are no writes and the engine goes directly to DONE.
  - SCROLL_UP: for a = 0 .. (ROWS-1)*COLUMNS-1 ascending, performs ram[a] ← ram[a+COLUMNS] via READ→WAIT→WRITE. It then fills the last row with cmdFill.
  - SCROLL_DOWN: for a = COLUMNS*ROWS-1 down to COLUMNS, performs ram[a] ← ram[a-COLUMNS]. It then fills row 0 with cmdFill.
  - READ issues the read. WAIT consumes one cycle. The read data is captured into an internal register exactly two edges after the read issue, independent of any host slot in between. WRITE writes the captured word.
  - FILL issues one write per available slot.
  - DONE pulses done for one cycle, then returns to IDLE: busy=0, cmdReady=1.
- Address arithmetic: ROWS*COLUMNS fits in 11 bits. Row offset = cmdRow*COLUMNS, computed in 11 bits with no wrap.
- Coherence: host writes to cells the engine is copying are not ordered against the engine. Software avoids them or waits for done.
- Reset, including mid-operation, immediately forces:
  - state IDLE
  - all ram* outputs 0
  - hostReady=0, hostDataOut=0, busy=0, done=0
  - cmdReady=1
  - RAM contents are left partially modified.

## Timing
- Host access latency: 2 cycles from the sample edge to hostReady. Host throughput is one access per 3 cycles.
- Engine cost, uncontended:
  - fill: 1 cycle per word
  - copy: 3 cycles per word
  - plus 1 cycle for DONE
  - FILL_ALL = 2001 cycles from acceptance to the done edge.
- A host access delays the engine by exactly 1 cycle. Engine progress is guaranteed because the host uses at most 1 of every 3 slots.
- done is asserted in the same cycle that busy falls.
- A command offered while busy is not accepted; cmdValid must be held.

## Test plan
- Reset mid-SCROLL_UP (at about 100 cycles) → next cycle: ramEnable=0, busy=0, cmdReady=1. A new FILL_ALL then completes normally.
- Host write 16'h1F41 to address 5, then host read of address 5 → hostReady 2 cycles after each sample; hostDataOut=16'h1F41.
- FILL_ALL with cmdFill=16'h0720 → done after 2001 cycles. Addresses 0..1999 read 16'h0720; address 2000 is unchanged.
- FILL_ROW cmdRow=24, fill 16'h4E2A → only addresses 1920..1999 written. FILL_ROW cmdRow=25 → no RAM writes; done on the cycle after acceptance.
- Preload ram[a]=a. Run SCROLL_UP with fill 16'h0000 → ram[a]=a+80 for a<1920, ram[1920..1999]=0. Run SCROLL_DOWN on the same preload → ram[a]=a-80 for a≥80, ram[0..79]=fill.
- Host read request every 3 cycles during FILL_ALL → every host access completes with 2-cycle latency. Engine finish is delayed by exactly the number of host slots taken. Final contents are correct.
